// File: rtl/zero_exec_pkg.sv
// rtl/zero_exec_pkg.sv - opcodes, FSM states, instruction layout and branch condition helper
// Purpose: shared definitions for zero_branch_exec and its program memory.
// Ports: none (package).
// Instruction layout, MSB to LSB: {op[3:0], immA, a[W-1:0], b[LA-1:0], tgt[PA-1:0]}.
package zero_exec_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_OUT  = 4'h2,
    OP_JMP  = 4'h3,
    OP_JEQ  = 4'h4,
    OP_JNE  = 4'h5,
    OP_JLT  = 4'h6,
    OP_JLE  = 4'h7,
    OP_JGT  = 4'h8,
    OP_JGE  = 4'h9,
    OP_EXP  = 4'hE,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_OUTWAIT,
    ST_DONE
  } state_e;

  function automatic int instr_width(input int w, input int la, input int pa);
    return 4 + 1 + w + la + pa;
  endfunction

  function automatic int b_lsb(input int pa);
    return pa;
  endfunction

  function automatic int a_lsb(input int la, input int pa);
    return pa + la;
  endfunction

  function automatic int imm_bit(input int w, input int la, input int pa);
    return pa + la + w;
  endfunction

  function automatic int op_lsb(input int w, input int la, input int pa);
    return pa + la + w + 1;
  endfunction

  // Branch decision from the unsigned compare of A against B.
  function automatic logic cond_eval(input op_e op, input logic eq, input logic lt);
    logic r;
    case (op)
      OP_JMP:  r = 1'b1;
      OP_JEQ:  r = eq;
      OP_JNE:  r = ~eq;
      OP_JLT:  r = lt;
      OP_JLE:  r = lt | eq;
      OP_JGT:  r = ~(lt | eq);
      OP_JGE:  r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zero_branch_exec_if.sv
// rtl/zero_branch_exec_if.sv - loader, output stream and status bundle of zero_branch_exec
// Purpose: groups the program load port, start, out valid/ready stream and run status.
// Ports: master = loader/consumer side, slave = executor side.
interface zero_branch_exec_if #(
  parameter int W  = 12,
  parameter int PA = 6,
  parameter int IW = 27,
  parameter int SW = 11
);
  logic          loadValid;
  logic [PA-1:0] loadAddr;
  logic [IW-1:0] loadData;
  logic          start;
  logic [W-1:0]  outData;
  logic          outValid;
  logic          outReady;
  logic          busy;
  logic          finished;
  logic          success;
  logic          timedOut;
  logic [SW-1:0] steps;

  modport master (
    output loadValid, loadAddr, loadData, start, outReady,
    input  outData, outValid, busy, finished, success, timedOut, steps
  );

  modport slave (
    input  loadValid, loadAddr, loadData, start, outReady,
    output outData, outValid, busy, finished, success, timedOut, steps
  );
endinterface

// File: rtl/zero_exec_prog_mem.sv
// rtl/zero_exec_prog_mem.sv - NProg x IW program store, one write port, one registered read port
// Purpose: holds the loaded Zero program; contents survive reset.
// Ports: i_clock; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request, o_rdata valid next cycle.
module zero_exec_prog_mem #(
  parameter int NProg = 64,
  parameter int PA    = 6,
  parameter int IW    = 27
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [PA-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [PA-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);
  logic [IW-1:0] r_mem [NProg];
  logic [IW-1:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/zero_branch_exec.sv
// rtl/zero_branch_exec.sv - executes a loaded Zero program (mov/out/jumps/halt) with an output stream
// Purpose: control FSM, local memory and output handshake around zero_exec_prog_mem.
// Ports: i_clock, i_resetN (async active-low); bus (zero_branch_exec_if.slave): load port,
//        start, outData/outValid/outReady stream, busy/finished/success/timedOut/steps.
// Option: ZERO_EXPECT_CHECK_EN adds the expected-output memory and compare.
module zero_branch_exec
  import zero_exec_pkg::*;
#(
  parameter int W        = 12,
  parameter int NLocal   = 16,
  parameter int NProg    = 64,
  parameter int MaxSteps = 1024,
  parameter int NExpect  = 8
) (
  input logic               i_clock,
  input logic               i_resetN,
  zero_branch_exec_if.slave bus
);
  localparam int LA = $clog2(NLocal);
  localparam int PA = $clog2(NProg);
  localparam int IW = instr_width(W, LA, PA);
  localparam int SW = $clog2(MaxSteps + 1);
  localparam int BL = b_lsb(PA);
  localparam int AL = a_lsb(LA, PA);
  localparam int IB = imm_bit(W, LA, PA);
  localparam int OL = op_lsb(W, LA, PA);
  localparam logic [PA:0]   IP_END   = (PA + 1)'(NProg);
  localparam logic [SW-1:0] STEP_MAX = SW'(MaxSteps);

  state_e        r_state, w_state_nxt;
  logic [PA:0]   r_ip;
  logic [SW-1:0] r_steps;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid, r_finished, r_timed_out;
  logic [W-1:0]  r_local [NLocal];

  logic          w_idle_like, w_start, w_load, w_prog_we, w_accept;
  logic [IW-1:0] w_instr;
  op_e           w_op;
  logic          w_imm, w_take;
  logic [W-1:0]  w_a, w_opa, w_opb;
  logic [LA-1:0] w_b;
  logic [PA:0]   w_ip_nxt;
  logic          w_exec, w_ip_load, w_mov_we, w_emit, w_finish, w_timeout;

  // Loads and start are only honoured while no program is running.
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start     = w_idle_like && bus.start;
  assign w_load      = w_idle_like && bus.loadValid;
  assign w_accept    = (r_state == ST_OUTWAIT) && bus.outReady;

  zero_exec_prog_mem #(.NProg(NProg), .PA(PA), .IW(IW)) u_prog (
    .i_clock (i_clock),
    .i_we    (w_prog_we),
    .i_waddr (bus.loadAddr),
    .i_wdata (bus.loadData),
    .i_re    (r_state == ST_FETCH),
    .i_raddr (r_ip[PA-1:0]),
    .o_rdata (w_instr)
  );

  assign w_op     = op_e'(w_instr[OL +: 4]);
  assign w_imm    = w_instr[IB];
  assign w_a      = w_instr[AL +: W];
  assign w_b      = w_instr[BL +: LA];
  assign w_opa    = w_imm ? w_a : r_local[w_a[LA-1:0]];
  assign w_opb    = r_local[w_b];
  assign w_take   = cond_eval(w_op, w_opa == w_opb, w_opa < w_opb);
  assign w_ip_nxt = w_take ? {1'b0, w_instr[PA-1:0]} : r_ip + 1'b1;

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exec      = 1'b0;
    w_ip_load   = 1'b0;
    w_mov_we    = 1'b0;
    w_emit      = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (bus.start) w_state_nxt = ST_FETCH;
      ST_FETCH:         w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        // The limit check comes first: the instruction at the limit is not executed.
        if (r_steps == STEP_MAX) begin
          w_timeout   = 1'b1;
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_exec    = 1'b1;
          w_ip_load = (w_op != OP_HALT);
          w_mov_we  = (w_op == OP_MOV);
          w_emit    = (w_op == OP_OUT);
          if (w_op == OP_HALT) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (w_op == OP_OUT) begin
            w_state_nxt = ST_OUTWAIT;
          end else if (w_ip_nxt >= IP_END) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_OUTWAIT: begin
        if (bus.outReady) begin
          // An OUT in the last slot runs off the end once its value is taken.
          if (r_ip >= IP_END) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_ip        <= '0;
      r_steps     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_finished  <= 1'b0;
      r_timed_out <= 1'b0;
      for (int i = 0; i < NLocal; i++) r_local[i] <= '0;
    end else if (w_start) begin
      r_ip        <= '0;
      r_steps     <= '0;
      r_finished  <= 1'b0;
      r_timed_out <= 1'b0;
      for (int i = 0; i < NLocal; i++) r_local[i] <= '0;
    end else begin
      if (w_exec)    r_steps <= r_steps + 1'b1;
      if (w_ip_load) r_ip <= w_ip_nxt;
      if (w_mov_we)  r_local[w_b] <= w_opa;
      if (w_emit) begin
        r_out_data  <= w_opa;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_finish)  r_finished <= 1'b1;
      if (w_timeout) r_timed_out <= 1'b1;
    end
  end

  assign bus.outData  = r_out_data;
  assign bus.outValid = r_out_valid;
  assign bus.busy     = (r_state == ST_FETCH) || (r_state == ST_EXEC) || (r_state == ST_OUTWAIT);
  assign bus.finished = r_finished;
  assign bus.timedOut = r_timed_out;
  assign bus.steps    = r_steps;

`ifdef ZERO_EXPECT_CHECK_EN
  localparam int EA = (NExpect > 1) ? $clog2(NExpect) : 1;
  localparam int EC = $clog2(NExpect + 1);

  logic [W-1:0]  r_expect [NExpect];
  logic [EC-1:0] r_expect_cnt, r_out_cnt;
  logic          r_mismatch;
  logic          w_is_exp, w_exp_we;

  // Op 0xE on the load port targets the expect list, not the program.
  assign w_is_exp  = (bus.loadData[OL +: 4] == OP_EXP);
  assign w_prog_we = w_load && !w_is_exp;
  assign w_exp_we  = w_load && w_is_exp && ({1'b0, bus.loadAddr} < (PA + 1)'(NExpect));

  always_ff @(posedge i_clock) begin
    if (w_exp_we) r_expect[bus.loadAddr[EA-1:0]] <= bus.loadData[W-1:0];
  end

  // Writing entry k defines the expected list as entries 0..k.
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_expect_cnt <= '0;
      r_out_cnt    <= '0;
      r_mismatch   <= 1'b0;
    end else begin
      if (w_exp_we) r_expect_cnt <= EC'(bus.loadAddr) + 1'b1;
      if (w_start) begin
        r_out_cnt  <= '0;
        r_mismatch <= 1'b0;
      end else if (w_accept) begin
        if ((r_out_cnt >= r_expect_cnt) || (r_expect[r_out_cnt[EA-1:0]] != r_out_data))
          r_mismatch <= 1'b1;
        if (r_out_cnt < EC'(NExpect)) r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  assign bus.success = r_finished & ~r_timed_out & ~r_mismatch & (r_out_cnt == r_expect_cnt);
`else
  assign w_prog_we   = w_load;
  assign bus.success = r_finished & ~r_timed_out;
`endif
endmodule

// File: tb/tb_zero_branch_exec.sv
// tb/tb_zero_branch_exec.sv - directed scoreboard bench for zero_branch_exec
module tb_zero_branch_exec;
  import zero_exec_pkg::*;

  localparam int W = 12, NLOCAL = 16, NPROG = 64, MAXSTEPS = 16, NEXPECT = 8;
  localparam int LA = 4, PA = 6, IW = 4 + 1 + W + LA + PA, SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zero_branch_exec_if #(.W(W), .PA(PA), .IW(IW), .SW(SW)) bus ();

  zero_branch_exec #(
    .W(W), .NLocal(NLOCAL), .NProg(NPROG), .MaxSteps(MAXSTEPS), .NExpect(NEXPECT)
  ) dut (
    .i_clock  (clk),
    .i_resetN (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  logic [IW-1:0] t1_prog [10];

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic imm, input logic [W-1:0] a,
                                       input logic [LA-1:0] b, input logic [PA-1:0] tgt);
    return {op, imm, a, b, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PA-1:0] addr, input logic [IW-1:0] data);
    bus.loadValid = 1'b1;
    bus.loadAddr  = addr;
    bus.loadData  = data;
    tick();
    bus.loadValid = 1'b0;
  endtask

  task automatic run_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.finished && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, 32'(bus.finished), 32'd1);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus.outValid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_outvalid"}, 32'(bus.outValid), 32'd1);
  endtask

  // Scoreboard: every accepted output is compared with the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && bus.outValid && bus.outReady) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL out_unexpected observed=%0d expected=none", bus.outData);
      end
      if (exp_q.size() > 0) check("out_data", 32'(bus.outData), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [3:0] t2_ops [5];
    int t2_a5 [5];
    int t2_a4 [5];
    t2_ops = '{OP_JNE, OP_JLT, OP_JLE, OP_JGT, OP_JGE};
    t2_a5  = '{0, 0, 1, 0, 1};
    t2_a4  = '{1, 1, 1, 0, 0};

    t1_prog[0] = mk(OP_NOP, 0, 0, 0, 0);
    t1_prog[1] = mk(OP_MOV, 1, 1, 0, 0);
    t1_prog[2] = mk(OP_MOV, 1, 2, 1, 0);
    t1_prog[3] = mk(OP_JEQ, 0, 0, 1, 8);
    t1_prog[4] = mk(OP_OUT, 1, 111, 0, 0);
    t1_prog[5] = mk(OP_JEQ, 0, 0, 0, 8);
    t1_prog[6] = mk(OP_OUT, 1, 999, 0, 0);
    t1_prog[7] = mk(OP_JMP, 0, 0, 0, 10);
    t1_prog[8] = mk(OP_OUT, 1, 333, 0, 0);
    t1_prog[9] = mk(OP_HALT, 0, 0, 0, 0);

    bus.loadValid = 1'b0;
    bus.loadAddr  = '0;
    bus.loadData  = '0;
    bus.start     = 1'b0;
    bus.outReady  = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_finished", 32'(bus.finished), 0);
    check("rst_success", 32'(bus.success), 0);
    check("rst_timedout", 32'(bus.timedOut), 0);
    check("rst_outvalid", 32'(bus.outValid), 0);
    check("rst_outdata", 32'(bus.outData), 0);
    check("rst_steps", 32'(bus.steps), 0);
    rst_n = 1'b1;
    tick();

    // T1: mov/jeq/out/jmp/halt program
    for (int i = 0; i < 10; i++) load(PA'(i), t1_prog[i]);
    exp_q.push_back(111);
    exp_q.push_back(333);
    run_start();
    check("t1_busy", 32'(bus.busy), 1);
    wait_done("t1");
    check("t1_success", 32'(bus.success), 1);
    check("t1_timedout", 32'(bus.timedOut), 0);
    check("t1_steps", 32'(bus.steps), 8);
    check("t1_drained", 32'(exp_q.size()), 0);

    // T2: each conditional jump with A=5 and A=4 against B=5
    load(0, mk(OP_MOV, 1, 5, 1, 0));
    load(2, mk(OP_OUT, 1, 0, 0, 0));
    load(3, mk(OP_HALT, 0, 0, 0, 0));
    load(4, mk(OP_OUT, 1, 1, 0, 0));
    load(5, mk(OP_HALT, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      load(1, mk(t2_ops[k % 5], 1, (k < 5) ? 12'd5 : 12'd4, 1, 4));
      exp_q.push_back((k < 5) ? t2_a5[k % 5] : t2_a4[k % 5]);
      run_start();
      wait_done("t2");
      check("t2_steps", 32'(bus.steps), 4);
      check("t2_success", 32'(bus.success), 1);
    end
    check("t2_drained", 32'(exp_q.size()), 0);

    // T3: consumer stall on the first output
    for (int i = 0; i < 10; i++) load(PA'(i), t1_prog[i]);
    bus.outReady = 1'b0;
    exp_q.push_back(111);
    exp_q.push_back(333);
    run_start();
    wait_out("t3");
    for (int c = 0; c < 20; c++) begin
      check("t3_hold_valid", 32'(bus.outValid), 1);
      check("t3_hold_data", 32'(bus.outData), 111);
      check("t3_hold_steps", 32'(bus.steps), 5);
      tick();
    end
    load(8, mk(OP_OUT, 1, 999, 0, 0));
    run_start();
    check("t3_busy_ignore_valid", 32'(bus.outValid), 1);
    check("t3_busy_ignore_steps", 32'(bus.steps), 5);
    bus.outReady = 1'b1;
    wait_done("t3");
    check("t3_steps", 32'(bus.steps), 8);
    check("t3_success", 32'(bus.success), 1);
    check("t3_drained", 32'(exp_q.size()), 0);

    // T4: endless loop runs into the step limit
    load(0, mk(OP_JMP, 0, 0, 0, 0));
    run_start();
    wait_done("t4");
    check("t4_timedout", 32'(bus.timedOut), 1);
    check("t4_success", 32'(bus.success), 0);
    check("t4_steps", 32'(bus.steps), MAXSTEPS);

    // T5: reset during OUTWAIT, then rerun; slot 0 is written in the start cycle
    load(0, t1_prog[0]);
    bus.outReady = 1'b0;
    run_start();
    wait_out("t5");
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_outvalid", 32'(bus.outValid), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    load(0, mk(OP_JMP, 0, 0, 0, 0));
    exp_q.push_back(111);
    exp_q.push_back(333);
    bus.loadValid = 1'b1;
    bus.loadAddr  = 0;
    bus.loadData  = t1_prog[0];
    bus.start     = 1'b1;
    tick();
    bus.loadValid = 1'b0;
    bus.start     = 1'b0;
    wait_done("t5");
    check("t5_steps", 32'(bus.steps), 8);
    check("t5_success", 32'(bus.success), 1);
    check("t5_timedout", 32'(bus.timedOut), 0);
    check("t5_drained", 32'(exp_q.size()), 0);

`ifdef ZERO_EXPECT_CHECK_EN
    // T6: expected-output list compare
    load(0, mk(OP_OUT, 1, 111, 0, 0));
    load(1, mk(OP_OUT, 1, 334, 0, 0));
    load(2, mk(OP_HALT, 0, 0, 0, 0));
    load(0, {4'hE, {(IW - 4 - W){1'b0}}, 12'd111});
    load(1, {4'hE, {(IW - 4 - W){1'b0}}, 12'd333});
    exp_q.push_back(111);
    exp_q.push_back(334);
    run_start();
    wait_done("t6a");
    check("t6a_success", 32'(bus.success), 0);
    load(0, {4'hE, {(IW - 4 - W){1'b0}}, 12'd111});
    exp_q.push_back(111);
    exp_q.push_back(334);
    run_start();
    wait_done("t6b");
    check("t6b_success", 32'(bus.success), 0);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
